// File: rtl/irqc_pkg.sv
// Shared IRQC definitions: register offsets, source bit map and VECTOR layout.
// Kept free of logic so bifrost and firmware headers can mirror it directly.
package irqc_pkg;

    localparam int NUM_SRC  = 8;
    localparam int NUM_REGS = 5;

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_PENDING = 3'd1,
        REG_ENABLE  = 3'd2,
        REG_MODE    = 3'd3,
        REG_VECTOR  = 3'd4
    } reg_off_e;

    localparam int SRC_VIA1_IRQ    = 0;
    localparam int SRC_VIA2_IRQ    = 1;
    localparam int SRC_UART_IRQ    = 2;
    localparam int SRC_UART_TXAIRQ = 3;
    localparam int SRC_UART_RXAIRQ = 4;
    localparam int SRC_UART_TXBIRQ = 5;
    localparam int SRC_UART_RXBIRQ = 6;
    localparam int SRC_SPARE       = 7;

    localparam int VEC_VALID_BIT = 7;

    // {valid, 4'b0, idx}: idx is the lowest set bit of act, all zero when act is empty.
    function automatic logic [7:0] vector_of(input logic [NUM_SRC-1:0] act);
        logic [7:0] v;
        v = 8'h00;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                v                = 8'h00;
                v[VEC_VALID_BIT] = 1'b1;
                v[2:0]           = 3'(i);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/irqc_sync.sv
// 2-flop synchroniser plus history flop per source, with an assertion-edge output.
// Edges are held off until the pipe has refilled after reset, so a source held active through reset never looks like a new edge.
module irqc_sync
    import irqc_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] din,
    output logic [NUM_SRC-1:0] level,
    output logic [NUM_SRC-1:0] rise
);

    logic [NUM_SRC-1:0] s1_q, s1_d;
    logic [NUM_SRC-1:0] s2_q, s2_d;
    logic [NUM_SRC-1:0] s3_q, s3_d;
    logic [1:0]         warm_q, warm_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        s3_d   = s2_q;
        warm_d = (warm_q != 2'd0) ? warm_q - 2'd1 : warm_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            warm_q <= 2'd3;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            warm_q <= warm_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q & {NUM_SRC{warm_q == 2'd0}};

endmodule

// File: rtl/irqc.sv
// Interrupt controller for bifrost: synchronised sources, per-bit level/edge pending,
// enable mask, lowest-index vector and a registered active-low IRQB request.
module irqc
    import irqc_pkg::*;
#(
    parameter logic [7:0] BASE = 8'h10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_out_en,
    input  logic [7:0] src_n,
    output logic       irq_n
);

    logic [7:0] level;
    logic [7:0] rise;

    logic [7:0] pend_q, pend_d;
    logic [7:0] enable_q, enable_d;
    logic [7:0] mode_q, mode_d;
    logic       irq_n_q, irq_n_d;

    logic [7:0] offset;
    logic       in_range;
    logic       wr_en;
    logic [7:0] w1c;
    logic [7:0] vector;

    irqc_sync u_sync (
        .clock (clock),
        .reset (reset),
        .din   (~src_n),
        .level (level),
        .rise  (rise)
    );

    // Unsigned wrap makes addresses below BASE land far out of range.
    assign offset   = addr - BASE;
    assign in_range = (offset < 8'(NUM_REGS));
    assign wr_en    = ~cs & ~rw & in_range;

    assign vector = vector_of(pend_q & enable_q);

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        w1c      = 8'h00;
        if (wr_en) begin
            if (offset[2:0] == REG_ENABLE)  enable_d = data_in;
            if (offset[2:0] == REG_MODE)    mode_d   = data_in;
            if (offset[2:0] == REG_PENDING) w1c      = data_in;
        end
    end

    // Edge set wins over a same-cycle W1C; level bits simply follow the synchronised input.
    always_comb begin
        pend_d  = (~mode_q & level) | (mode_q & (rise | (pend_q & ~w1c)));
        irq_n_d = ~|(pend_q & enable_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_q   <= 8'h00;
            enable_q <= 8'h00;
            mode_q   <= 8'h00;
            irq_n_q  <= 1'b1;
        end else begin
            pend_q   <= pend_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign irq_n       = irq_n_q;
    assign data_out_en = ~cs & rw & in_range;

    always_comb begin
        data_out = 8'h00;
        if (data_out_en) begin
            case (offset[2:0])
                REG_STATUS:  data_out = level;
                REG_PENDING: data_out = pend_q;
                REG_ENABLE:  data_out = enable_q;
                REG_MODE:    data_out = mode_q;
                REG_VECTOR:  data_out = vector;
                default:     data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_irqc.sv
// Directed bench for irqc: latency, edge/level pending, W1C collision, priority vector, reset and bus decode.
module tb_irqc;
    import irqc_pkg::*;

    localparam logic [7:0] BASE = 8'h10;

    logic       clock;
    logic       reset;
    logic       cs;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_out_en;
    logic [7:0] src_n;
    logic       irq_n;

    int total;
    int bad;

    irqc #(.BASE(BASE)) dut (
        .clock       (clock),
        .reset       (reset),
        .cs          (cs),
        .rw          (rw),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_out_en (data_out_en),
        .src_n       (src_n),
        .irq_n       (irq_n)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", tag, got, exp);
        end
    endtask

    // Both bus tasks assume they are entered just after a falling edge.
    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        cs      = 1'b0;
        rw      = 1'b0;
        addr    = BASE + 8'(off);
        data_in = d;
        @(negedge clock);
        cs = 1'b1;
        rw = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [7:0] exp);
        cs   = 1'b0;
        rw   = 1'b1;
        addr = BASE + 8'(off);
        #1;
        chk(tag, data_out, exp);
        cs = 1'b1;
    endtask

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        cs      = 1'b1;
        rw      = 1'b1;
        addr    = 8'h00;
        data_in = 8'h00;
        src_n   = 8'hFF;
        clocks(3);
        reset = 1'b1;
        clocks(1);

        // reset state
        chk("rst_irq_n", {7'd0, irq_n}, 8'h01);
        rd("rst_status", 3'd0, 8'h00);
        rd("rst_pending", 3'd1, 8'h00);
        rd("rst_enable", 3'd2, 8'h00);
        rd("rst_mode", 3'd3, 8'h00);
        rd("rst_vector", 3'd4, 8'h00);
        @(negedge clock);

        // level mode on bit 2, latency both ways
        wr(3'd2, 8'h04);
        wr(3'd3, 8'h00);
        src_n[2] = 1'b0;
        @(posedge clock);  // E0
        @(posedge clock);  // E1
        @(posedge clock);  // E2
        #1 chk("lvl_irq_e2", {7'd0, irq_n}, 8'h01);
        @(posedge clock);  // E3
        #1 chk("lvl_irq_e3", {7'd0, irq_n}, 8'h00);
        @(negedge clock);
        rd("lvl_vector", 3'd4, 8'h82);
        rd("lvl_status", 3'd0, 8'h04);
        src_n[2] = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1 chk("lvl_off_e2", {7'd0, irq_n}, 8'h00);
        @(posedge clock);
        #1 chk("lvl_off_e3", {7'd0, irq_n}, 8'h01);
        @(negedge clock);

        // edge mode on bit 0
        wr(3'd3, 8'h01);
        wr(3'd2, 8'h01);
        src_n[0] = 1'b0;
        @(negedge clock);
        src_n[0] = 1'b1;
        clocks(5);
        rd("edge_pending", 3'd1, 8'h01);
        chk("edge_irq_lo", {7'd0, irq_n}, 8'h00);
        clocks(4);
        chk("edge_irq_held", {7'd0, irq_n}, 8'h00);
        wr(3'd1, 8'h00);
        clocks(2);
        rd("edge_w0_pending", 3'd1, 8'h01);
        chk("edge_w0_irq", {7'd0, irq_n}, 8'h00);
        wr(3'd1, 8'h01);
        @(posedge clock);
        #1 chk("edge_w1c_irq", {7'd0, irq_n}, 8'h01);
        @(negedge clock);
        rd("edge_w1c_pending", 3'd1, 8'h00);

        // priority vector from level bits 1 and 5
        wr(3'd3, 8'h00);
        src_n = 8'hDD;
        clocks(4);
        wr(3'd2, 8'hFF);
        rd("prio_ff", 3'd4, 8'h81);
        wr(3'd2, 8'hFD);
        rd("prio_fd", 3'd4, 8'h85);
        wr(3'd2, 8'h00);
        rd("prio_00", 3'd4, 8'h00);
        clocks(2);
        chk("prio_irq", {7'd0, irq_n}, 8'h01);
        src_n = 8'hFF;
        clocks(4);

        // W1C of bit 3 landing on the same edge that sets it
        wr(3'd3, 8'h08);
        src_n[3] = 1'b0;
        @(posedge clock);  // E0
        @(posedge clock);  // E1
        @(negedge clock);
        wr(3'd1, 8'h08);   // sampled at E2, where the edge also pends
        rd("coll_pending", 3'd1, 8'h08);
        wr(3'd1, 8'h08);
        rd("coll_cleared", 3'd1, 8'h00);
        src_n[3] = 1'b1;
        clocks(4);

        // reset mid-operation with bit 0 held active
        wr(3'd3, 8'h01);
        wr(3'd2, 8'h01);
        src_n[0] = 1'b0;
        clocks(5);
        chk("prerst_irq", {7'd0, irq_n}, 8'h00);
        rd("prerst_pending", 3'd1, 8'h01);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("midrst_irq", {7'd0, irq_n}, 8'h01);
        rd("midrst_status", 3'd0, 8'h00);
        rd("midrst_pending", 3'd1, 8'h00);
        rd("midrst_enable", 3'd2, 8'h00);
        rd("midrst_mode", 3'd3, 8'h00);
        rd("midrst_vector", 3'd4, 8'h00);
        @(negedge clock);
        wr(3'd3, 8'h01);
        wr(3'd2, 8'h01);
        clocks(6);
        rd("norepend_pending", 3'd1, 8'h00);
        chk("norepend_irq", {7'd0, irq_n}, 8'h01);
        rd("norepend_status", 3'd0, 8'h01);

        // bus decode
        cs   = 1'b0;
        rw   = 1'b1;
        addr = BASE + 8'd5;
        #1;
        chk("oor_en", {7'd0, data_out_en}, 8'h00);
        chk("oor_data", data_out, 8'h00);
        cs   = 1'b1;
        addr = BASE;
        #1;
        chk("cs_hi_en", {7'd0, data_out_en}, 8'h00);
        chk("cs_hi_data", data_out, 8'h00);
        @(negedge clock);
        wr(3'd0, 8'hAA);
        rd("status_wr", 3'd0, 8'h01);
        cs      = 1'b0;
        rw      = 1'b0;
        addr    = BASE + 8'd5;
        data_in = 8'hFF;
        @(negedge clock);
        cs = 1'b1;
        rw = 1'b1;
        rd("oor_wr_enable", 3'd2, 8'h01);
        rd("oor_wr_mode", 3'd3, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
